// File: rtl/memory_arbiter_pkg.sv
// Shared types for the RAM-port arbiter: RAM handshake states, arbiter FSM states
// and the default icache-starvation bound.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  localparam int ARB_MAXDSTREAK = 4;

  // dcache first unless icache has been starved; then icache; then a lone dcache request.
  function automatic arb_state_t arb_pick(input logic i_req, input logic d_req,
                                          input logic starve);
    if (d_req && !starve) return ARB_D;
    else if (i_req)       return ARB_I;
    else if (d_req)       return ARB_D;
    else                  return ARB_IDLE;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Shares one RAM port between icache (read-only) and dcache (read/write); dcache has priority,
// a streak counter bounds icache starvation, and dcache two-word blocks are never split.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAXDSTREAK = ARB_MAXDSTREAK
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              iREN,
  input  logic [AW-1:0]                     iaddr,
  output logic                              iwait,
  output logic [DW-1:0]                     iload,
  input  logic                              dREN,
  input  logic                              dWEN,
  input  logic [AW-1:0]                     daddr,
  input  logic [DW-1:0]                     dstore,
  input  logic                              dblof,
  output logic                              dwait,
  output logic [DW-1:0]                     dload,
  output logic                              ramREN,
  output logic                              ramWEN,
  output logic [AW-1:0]                     ramaddr,
  output logic [DW-1:0]                     ramstore,
  input  logic [DW-1:0]                     ramload,
  input  logic [1:0]                        ramstate,
  output logic [1:0]                        o_dbg_state,
  output logic [$clog2(MAXDSTREAK+1)-1:0]   o_dbg_streak
);

  localparam int SW = $clog2(MAXDSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAXDSTREAK);

  arb_state_t    r_state;
  logic [SW-1:0] r_streak;

  arb_state_t    w_state_nxt;
  arb_state_t    w_pick;
  logic [SW-1:0] w_streak_nxt;
  logic          w_dreq;
  logic          w_ram_access;
  logic          w_d_done;
  logic          w_i_done;
  logic          w_starve;

  // Handshake: a word completes in the cycle the owner's request is high and ramstate is
  // ACCESS; the owner's wait is low for exactly that cycle. ERROR/BUSY/FREE keep it waiting.
  always_comb begin
    w_dreq       = dREN | dWEN;
    w_ram_access = (ramstate == ACCESS);
    w_d_done     = (r_state == ARB_D) && w_dreq && w_ram_access;
    w_i_done     = (r_state == ARB_I) && iREN && w_ram_access;

    w_streak_nxt = r_streak;
    if (!iREN || w_i_done)
      w_streak_nxt = '0;
    else if (w_d_done && (r_streak != STREAK_MAX))
      w_streak_nxt = r_streak + 1'b1;

    // Uses the post-update streak so the MAXDSTREAK-th dcache word hands over immediately.
    w_starve = iREN && (w_streak_nxt == STREAK_MAX);
    w_pick   = arb_pick(iREN, w_dreq, w_starve);

    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: w_state_nxt = w_pick;
      ARB_D: begin
        if (!w_dreq)
          w_state_nxt = w_pick;
        else if (w_d_done)
          w_state_nxt = dblof ? w_pick : ARB_D;
      end
      ARB_I: begin
        if (!iREN || w_i_done)
          w_state_nxt = w_pick;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase

    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    if (r_state == ARB_D) begin
      ramWEN   = dWEN;
      ramREN   = dREN & ~dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
      dwait    = ~w_d_done;
      dload    = ramload;
    end else if (r_state == ARB_I) begin
      ramREN   = iREN;
      ramaddr  = iaddr;
      iwait    = ~w_i_done;
      iload    = ramload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ARB_IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  assign o_dbg_state  = r_state;
  assign o_dbg_streak = r_streak;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: RAM data is modelled as address XOR a key, expected
// read data is queued when a request is driven and compared when the owner's wait drops.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [DW-1:0] KEY = 32'h5A5A_0000;

  logic          CLK;
  logic          nRST;
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          dblof;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_streak;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];

  memory_arbiter #(.AW(AW), .DW(DW), .MAXDSTREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dblof(dblof),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .o_dbg_state(dbg_state), .o_dbg_streak(dbg_streak)
  );

  assign ramload = ramaddr ^ KEY;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
    #1;
  endtask

  // scoreboard: completions are popped against the expected queues
  always @(negedge CLK) begin
    if (nRST) begin
      if (!iwait) begin
        if (exp_i_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL i_completion observed=unexpected expected=none");
        end else chk("iload", 64'(iload), 64'(exp_i_q.pop_front()));
      end
      if (!dwait) begin
        if (exp_d_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL d_completion observed=unexpected expected=none");
        end else chk("dload", 64'(dload), 64'(exp_d_q.pop_front()));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; dblof = 1'b0; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iwait", 64'(iwait), 64'd1);
    chk("rst_dwait", 64'(dwait), 64'd1);
    chk("rst_ramREN", 64'(ramREN), 64'd0);
    chk("rst_ramWEN", 64'(ramWEN), 64'd0);
    chk("rst_ramaddr", 64'(ramaddr), 64'd0);
    chk("rst_ramstore", 64'(ramstore), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
    chk("rst_streak", 64'(dbg_streak), 64'd0);
    mid();
    nRST = 1'b1;

    // 1: icache alone, two BUSY cycles then ACCESS
    cyc();
    iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY;
    #1 chk("t1_idle_state", 64'(dbg_state), 64'(ARB_IDLE));
    chk("t1_idle_ramREN", 64'(ramREN), 64'd0);
    cyc(); #1;
    chk("t1_state_i", 64'(dbg_state), 64'(ARB_I));
    chk("t1_ramREN", 64'(ramREN), 64'd1);
    chk("t1_ramaddr", 64'(ramaddr), 64'h100);
    chk("t1_iwait_busy0", 64'(iwait), 64'd1);
    cyc(); #1;
    chk("t1_iwait_busy1", 64'(iwait), 64'd1);
    cyc();
    ramstate = ACCESS; exp_i_q.push_back(32'h100 ^ KEY);
    #1 chk("t1_iwait_access", 64'(iwait), 64'd0);
    chk("t1_dwait", 64'(dwait), 64'd1);
    chk("t1_dload_hidden", 64'(dload), 64'd0);
    mid();
    iREN = 1'b0; ramstate = FREE;
    cyc(); #1;
    chk("t1_back_idle", 64'(dbg_state), 64'(ARB_IDLE));

    // 2: collision from idle, dcache first then icache without a bubble
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS;
    exp_d_q.push_back(32'h300 ^ KEY);
    exp_i_q.push_back(32'h200 ^ KEY);
    #1 chk("t2_idle_ramREN", 64'(ramREN), 64'd0);
    cyc(); #1;
    chk("t2_state_d", 64'(dbg_state), 64'(ARB_D));
    chk("t2_ramaddr_d", 64'(ramaddr), 64'h300);
    chk("t2_dwait", 64'(dwait), 64'd0);
    chk("t2_iwait", 64'(iwait), 64'd1);
    chk("t2_iload_hidden", 64'(iload), 64'd0);
    mid();
    dREN = 1'b0;
    cyc(); #1;
    chk("t2_state_i", 64'(dbg_state), 64'(ARB_I));
    chk("t2_ramaddr_i", 64'(ramaddr), 64'h200);
    chk("t2_iwait", 64'(iwait), 64'd0);
    mid();
    iREN = 1'b0; ramstate = FREE;
    cyc(); #1;
    chk("t2_back_idle", 64'(dbg_state), 64'(ARB_IDLE));

    // 3: write pair then read pair held against a waiting icache
    iREN = 1'b1; iaddr = 32'h400; dWEN = 1'b1; daddr = 32'h500; dstore = 32'hCAFE_0000;
    dblof = 1'b0; ramstate = ACCESS;
    exp_d_q.push_back(32'h500 ^ KEY);
    cyc(); #1;
    chk("t3_state_d", 64'(dbg_state), 64'(ARB_D));
    chk("t3_ramWEN", 64'(ramWEN), 64'd1);
    chk("t3_ramREN", 64'(ramREN), 64'd0);
    chk("t3_ramstore", 64'(ramstore), 64'hCAFE_0000);
    cyc();
    daddr = 32'h504; dstore = 32'hCAFE_0004; dblof = 1'b1;
    exp_d_q.push_back(32'h504 ^ KEY);
    #1 chk("t3_lock_w1", 64'(dbg_state), 64'(ARB_D));
    chk("t3_streak1", 64'(dbg_streak), 64'd1);
    chk("t3_ramaddr_w1", 64'(ramaddr), 64'h504);
    chk("t3_iwait_held", 64'(iwait), 64'd1);
    cyc();
    dWEN = 1'b0; dREN = 1'b1; dblof = 1'b0; daddr = 32'h600;
    exp_d_q.push_back(32'h600 ^ KEY);
    #1 chk("t3_read_state", 64'(dbg_state), 64'(ARB_D));
    chk("t3_read_ramREN", 64'(ramREN), 64'd1);
    chk("t3_read_ramWEN", 64'(ramWEN), 64'd0);
    chk("t3_streak2", 64'(dbg_streak), 64'd2);
    cyc();
    dblof = 1'b1; daddr = 32'h604;
    exp_d_q.push_back(32'h604 ^ KEY);
    #1 chk("t3_lock_r1", 64'(dbg_state), 64'(ARB_D));
    mid();
    dREN = 1'b0; dblof = 1'b0;
    exp_i_q.push_back(32'h400 ^ KEY);
    cyc(); #1;
    chk("t3_state_i", 64'(dbg_state), 64'(ARB_I));
    chk("t3_ramaddr_i", 64'(ramaddr), 64'h400);
    chk("t3_streak3", 64'(dbg_streak), 64'd3);
    mid();
    iREN = 1'b0; ramstate = FREE;
    cyc(); #1;
    chk("t3_idle", 64'(dbg_state), 64'(ARB_IDLE));
    chk("t3_streak_clr", 64'(dbg_streak), 64'd0);

    // 4: starvation bound, icache forced in after four dcache words
    iREN = 1'b1; iaddr = 32'h700; dREN = 1'b1; dblof = 1'b1; daddr = 32'h800;
    ramstate = ACCESS;
    exp_d_q.push_back(32'h800 ^ KEY);
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_state_d", 64'(dbg_state), 64'(ARB_D));
      chk("t4_streak", 64'(dbg_streak), 64'(k));
      chk("t4_ramaddr", 64'(ramaddr), 64'(32'h800 + 4 * k));
      mid();
      if (k < 3) begin
        daddr = 32'h800 + 4 * (k + 1);
        exp_d_q.push_back(daddr ^ KEY);
      end else exp_i_q.push_back(32'h700 ^ KEY);
      cyc();
    end
    #1 chk("t4_forced_i", 64'(dbg_state), 64'(ARB_I));
    chk("t4_streak_sat", 64'(dbg_streak), 64'd4);
    chk("t4_ramaddr_i", 64'(ramaddr), 64'h700);
    chk("t4_dwait", 64'(dwait), 64'd1);
    cyc();
    ramstate = FREE; dREN = 1'b0; iREN = 1'b0;
    #1 chk("t4_back_to_d", 64'(dbg_state), 64'(ARB_D));
    chk("t4_streak_reset", 64'(dbg_streak), 64'd0);
    cyc(); #1;
    chk("t4_idle", 64'(dbg_state), 64'(ARB_IDLE));

    // 5: dcache withdraws while BUSY, then ERROR holds the icache grant
    dREN = 1'b1; daddr = 32'h900; ramstate = BUSY;
    cyc(); #1;
    chk("t5_state_d", 64'(dbg_state), 64'(ARB_D));
    chk("t5_ramREN", 64'(ramREN), 64'd1);
    cyc();
    dREN = 1'b0; iREN = 1'b1; iaddr = 32'hA00;
    #1 chk("t5_withdraw_ramREN", 64'(ramREN), 64'd0);
    chk("t5_withdraw_dwait", 64'(dwait), 64'd1);
    cyc();
    ramstate = ERROR;
    #1 chk("t5_state_i", 64'(dbg_state), 64'(ARB_I));
    chk("t5_ramaddr", 64'(ramaddr), 64'hA00);
    chk("t5_err_iwait0", 64'(iwait), 64'd1);
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      chk("t5_err_state", 64'(dbg_state), 64'(ARB_I));
      chk("t5_err_iwait", 64'(iwait), 64'd1);
    end
    cyc();
    ramstate = ACCESS; exp_i_q.push_back(32'hA00 ^ KEY);
    #1 chk("t5_iwait_access", 64'(iwait), 64'd0);
    mid();
    iREN = 1'b0; ramstate = FREE;
    cyc(); #1;
    chk("t5_idle", 64'(dbg_state), 64'(ARB_IDLE));

    // 6: reset pulsed in the middle of a dcache write block
    iREN = 1'b1; iaddr = 32'hC00; dWEN = 1'b1; daddr = 32'hB00; dstore = 32'hBEEF_0000;
    dblof = 1'b0; ramstate = ACCESS;
    exp_d_q.push_back(32'hB00 ^ KEY);
    cyc(); #1;
    chk("t6_state_d", 64'(dbg_state), 64'(ARB_D));
    cyc();
    daddr = 32'hB04; dblof = 1'b1; ramstate = BUSY;
    #1 chk("t6_ramWEN", 64'(ramWEN), 64'd1);
    chk("t6_streak1", 64'(dbg_streak), 64'd1);
    #1 nRST = 1'b0;
    #1 chk("t6_rst_ramWEN", 64'(ramWEN), 64'd0);
    chk("t6_rst_dwait", 64'(dwait), 64'd1);
    chk("t6_rst_iwait", 64'(iwait), 64'd1);
    chk("t6_rst_ramaddr", 64'(ramaddr), 64'd0);
    chk("t6_rst_state", 64'(dbg_state), 64'(ARB_IDLE));
    chk("t6_rst_streak", 64'(dbg_streak), 64'd0);
    mid();
    iREN = 1'b0; dWEN = 1'b0; dblof = 1'b0; ramstate = FREE; nRST = 1'b1;
    cyc(); #1;
    chk("t6_idle", 64'(dbg_state), 64'(ARB_IDLE));

    chk("exp_i_q_drained", 64'(exp_i_q.size()), 64'd0);
    chk("exp_d_q_drained", 64'(exp_d_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
